// File: rtl/phys_reg_free_list_if.sv
// Rename/retire interface of the physical-register free list.
// The master is the rename/retire pipeline; the slave is the free list.
interface phys_reg_free_list_if #(
   parameter int NUM_ENTRIES = 64
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);

   logic             alloc_req;
   logic             alloc_valid;
   logic [IDX_W-1:0] alloc_idx;
   logic             retire_valid;
   logic [IDX_W-1:0] retire_new_idx;
   logic [IDX_W-1:0] retire_old_idx;
   logic             flush;
   logic [IDX_W:0]   free_count;
   logic             double_free_err;

   modport master (
      output alloc_req, retire_valid, retire_new_idx, retire_old_idx, flush,
      input  alloc_valid, alloc_idx, free_count, double_free_err
   );

   modport slave (
      input  alloc_req, retire_valid, retire_new_idx, retire_old_idx, flush,
      output alloc_valid, alloc_idx, free_count, double_free_err
   );
endinterface

// File: rtl/phys_reg_free_list.sv
// Physical-register free list: speculative and retired busy bitmaps, lowest-free
// allocation, reclaim at retire, and rollback to the retired map on flush.
module phys_reg_free_list #(
   parameter int NUM_ENTRIES  = 64,
   parameter int NUM_RESERVED = 32
) (
   input logic                clk,
   input logic                rst,
   phys_reg_free_list_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [NUM_ENTRIES-1:0] RESET_MAP =
      {NUM_ENTRIES{1'b1}} >> (NUM_ENTRIES - NUM_RESERVED);
   localparam logic [IDX_W:0] RESET_FREE = (IDX_W+1)'(NUM_ENTRIES - NUM_RESERVED);

   logic [NUM_ENTRIES-1:0] spec_busy, arch_busy;
   logic [NUM_ENTRIES-1:0] spec_next, arch_next;
   logic [IDX_W:0]         free_count, free_next, arch_free;
   logic                   double_free_err;
   logic [IDX_W-1:0]       first_free;
   logic                   alloc_fire, old_busy, release_ok, double_free;

   // Lowest-index free register; scanning downward lets the lowest hit win.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      first_free = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!spec_busy[i]) first_free = IDX_W'(i);
      end
   end

   assign bus.alloc_valid     = (free_count != '0) && !bus.flush;
   assign bus.alloc_idx       = first_free;
   assign bus.free_count      = free_count;
   assign bus.double_free_err = double_free_err;

   assign alloc_fire  = bus.alloc_req && bus.alloc_valid;
   assign old_busy    = spec_busy[bus.retire_old_idx];
   assign release_ok  = bus.retire_valid && old_busy &&
                        (bus.retire_new_idx != bus.retire_old_idx);
   assign double_free = bus.retire_valid && !old_busy;

   // Retired map; the new mapping is written last so new==old leaves it busy.
   always_comb begin
      arch_next = arch_busy;
      if (bus.retire_valid) begin
         arch_next[bus.retire_old_idx] = 1'b0;
         arch_next[bus.retire_new_idx] = 1'b1;
      end
      arch_free = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         arch_free = arch_free + {{IDX_W{1'b0}}, ~arch_next[i]};
      end
   end

   always_comb begin
      spec_next = spec_busy;
      free_next = free_count;
      if (bus.flush) begin
         spec_next = arch_next;
         free_next = arch_free;
      end else begin
         if (alloc_fire) spec_next[first_free] = 1'b1;
         if (release_ok) spec_next[bus.retire_old_idx] = 1'b0;
         free_next = free_count - {{IDX_W{1'b0}}, alloc_fire}
                                + {{IDX_W{1'b0}}, release_ok};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the bitmaps are plain flops, not RAM, so they can and must be
         // reset to the initial architectural mapping.
         spec_busy       <= RESET_MAP;
         arch_busy       <= RESET_MAP;
         free_count      <= RESET_FREE;
         double_free_err <= 1'b0;
      end else begin
         spec_busy       <= spec_next;
         arch_busy       <= arch_next;
         free_count      <= free_next;
         double_free_err <= double_free_err | double_free;
      end
   end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a bitmap reference model predicts the
// visible outputs after each clock, and each scenario task compares them.
module tb_phys_reg_free_list;
   localparam int N = 64;
   localparam int R = 32;
   localparam int W = $clog2(N);

   typedef struct packed {
      logic [W:0]   free_count;
      logic [W-1:0] idx;
      logic         valid;
      logic         dfe;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   phys_reg_free_list_if #(.NUM_ENTRIES(N)) bus ();

   phys_reg_free_list #(.NUM_ENTRIES(N), .NUM_RESERVED(R)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [N-1:0] m_spec, m_arch;
   logic         m_dfe;
   obs_t         sb[$];
   int           errors = 0;
   int           checks = 0;

   function automatic obs_t observe();
      obs_t o;
      o.free_count = bus.free_count;
      o.idx        = bus.alloc_idx;
      o.valid      = bus.alloc_valid;
      o.dfe        = bus.double_free_err;
      return o;
   endfunction

   // Outputs the model expects with flush low.
   function automatic obs_t model_view();
      obs_t o;
      int   cnt = 0;
      int   low = -1;
      for (int i = 0; i < N; i++) begin
         if (!m_spec[i]) begin
            cnt++;
            if (low < 0) low = i;
         end
      end
      o.free_count = (W+1)'(cnt);
      o.idx        = (low < 0) ? '0 : W'(low);
      o.valid      = (cnt != 0);
      o.dfe        = m_dfe;
      return o;
   endfunction

   task automatic clear_inputs();
      bus.alloc_req      = 1'b0;
      bus.retire_valid   = 1'b0;
      bus.retire_new_idx = '0;
      bus.retire_old_idx = '0;
      bus.flush          = 1'b0;
   endtask

   task automatic drive(input logic a, input logic rv, input int nw, input int od,
                        input logic fl);
      @(negedge clk);
      bus.alloc_req      = a;
      bus.retire_valid   = rv;
      bus.retire_new_idx = W'(nw);
      bus.retire_old_idx = W'(od);
      bus.flush          = fl;
      #1;
   endtask

   // Advance the model with the driven inputs, push its prediction, clock the DUT.
   task automatic step();
      obs_t         cur = model_view();
      logic [N-1:0] an  = m_arch;
      logic [N-1:0] sn  = m_spec;
      int           od  = int'(bus.retire_old_idx);
      int           nw  = int'(bus.retire_new_idx);
      if (bus.retire_valid) begin
         an[od] = 1'b0;
         an[nw] = 1'b1;
         if (!m_spec[od]) m_dfe = 1'b1;
      end
      if (bus.flush) begin
         sn = an;
      end else begin
         if (bus.alloc_req && cur.valid) sn[cur.idx] = 1'b1;
         if (bus.retire_valid && m_spec[od] && nw != od) sn[od] = 1'b0;
      end
      m_spec = sn;
      m_arch = an;
      sb.push_back(model_view());
      @(posedge clk);
      #1;
      clear_inputs();
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.alloc_req = 1'b1;
      bus.flush     = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      m_spec = {N{1'b1}} >> (N - R);
      m_arch = m_spec;
      m_dfe  = 1'b0;
      sb.delete();
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.free_count !== 7'd32) begin
         errors++;
         $display("FAIL reset_free_count: got %0d want 32", bus.free_count);
      end
      checks++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_idx !== 6'd32) begin
         errors++;
         $display("FAIL reset_offer: got valid=%0b idx=%0d want valid=1 idx=32",
                  bus.alloc_valid, bus.alloc_idx);
      end
      checks++;
      if (bus.double_free_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_dfe: got %0b want 0", bus.double_free_err);
      end
   endtask

   task automatic test_fill();
      obs_t exp, got;
      for (int i = 0; i < N - R; i++) begin
         drive(1'b1, 1'b0, 0, 0, 1'b0);
         checks++;
         if (bus.alloc_idx !== W'(R + i)) begin
            errors++;
            $display("FAIL fill_offer[%0d]: got %0d want %0d", i, bus.alloc_idx, R + i);
         end
         step();
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL fill[%0d]: got %h want %h", i, got, exp);
         end
      end
      checks++;
      if (bus.free_count !== '0 || bus.alloc_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_empty: got fc=%0d valid=%0b want fc=0 valid=0",
                  bus.free_count, bus.alloc_valid);
      end
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got.free_count !== '0) begin
         errors++;
         $display("FAIL alloc_when_empty: got %h want %h", got, exp);
      end
   endtask

   task automatic test_retire_full();
      obs_t exp, got;
      drive(1'b0, 1'b1, 40, 5, 1'b0);
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got.free_count !== 7'd1 || got.idx !== 6'd5) begin
         errors++;
         $display("FAIL retire_full: got %h want %h (fc=1 idx=5)", got, exp);
      end
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got.free_count !== '0) begin
         errors++;
         $display("FAIL realloc_5: got %h want %h", got, exp);
      end
   endtask

   task automatic test_flush();
      obs_t exp, got;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 0, 0, 1'b0);
         step();
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL flush_alloc[%0d]: got %h want %h", i, got, exp);
         end
      end
      drive(1'b0, 1'b1, 32, 3, 1'b0);
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL flush_retire: got %h want %h", got, exp);
      end
      drive(1'b1, 1'b0, 0, 0, 1'b1);
      checks++;
      if (bus.alloc_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_valid: got %0b want 0", bus.alloc_valid);
      end
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got.free_count !== 7'd32 || got.idx !== 6'd3) begin
         errors++;
         $display("FAIL flush_restore: got %h want %h (fc=32 idx=3)", got, exp);
      end
      // Speculative 33 and 34 were discarded, so they come back after 3.
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got.idx !== 6'd33) begin
         errors++;
         $display("FAIL flush_next: got %h want %h (idx=33)", got, exp);
      end
   endtask

   task automatic test_double_free();
      obs_t exp, got;
      apply_reset();
      drive(1'b0, 1'b1, 20, 50, 1'b0);
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got.dfe !== 1'b1 || got.free_count !== 7'd32) begin
         errors++;
         $display("FAIL double_free: got %h want %h (dfe=1 fc=32)", got, exp);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 0, 0, 1'b0);
         step();
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp || got.dfe !== 1'b1) begin
            errors++;
            $display("FAIL dfe_sticky[%0d]: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_alloc_retire_same();
      obs_t exp, got;
      apply_reset();
      drive(1'b1, 1'b1, 10, 7, 1'b0);
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got.free_count !== 7'd32 || got.idx !== 6'd7) begin
         errors++;
         $display("FAIL alloc_retire: got %h want %h (fc=32 idx=7)", got, exp);
      end
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      step();
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got.idx !== 6'd33 || got.free_count !== 7'd31) begin
         errors++;
         $display("FAIL alloc_after_same: got %h want %h (idx=33 fc=31)", got, exp);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_fill();
      test_retire_full();
      test_flush();
      test_double_free();
      test_alloc_retire_same();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
